// File: rtl/scan_pkg.sv
// Shared encodings for the scan sequencer: FSM state codes, mode codes and default select width.
package scan_pkg;

    localparam int SEL_W_DEF = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_SWEEP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] M_UP    = 2'b00;
    localparam logic [1:0] M_DN    = 2'b01;
    localparam logic [1:0] M_SWEEP = 2'b10;
    localparam logic [1:0] M_HOLD  = 2'b11;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the last count as the step tick.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    // One bit minimum so DIV=1 still has a legal (constant-zero) counter.
    localparam int              PC_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(DIV - 1);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    assign tick = en && (pc_q == PC_LAST);

    always_comb begin
        pc_d = pc_q;
        if (clr || tick) begin
            pc_d = '0;
        end else if (en) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/scan_seq_3b.sv
// Registered select sequencer for the 3-to-8 decoder: continuous up/down stepping or a one-shot
// 0..LAST sweep with busy/done handshake, all stepping paced by the tick_gen prescaler.
module scan_seq_3b
    import scan_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             wrap,
    output logic             busy,
    output logic             done
);

    localparam logic [SEL_W-1:0] SEL_LAST = '1;

    logic [1:0]       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             sel_valid_q, sel_valid_d;
    logic             wrap_q, wrap_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             clr;
    logic             tick;

    function automatic logic [SEL_W-1:0] step_sel(input logic [SEL_W-1:0] cur, input logic down);
        return down ? cur - 1'b1 : cur + 1'b1;
    endfunction

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wrap_d  = 1'b0;
        clr     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    if (load) begin
                        sel_d = load_val;
                        clr   = 1'b1;
                    end
                    if (mode == M_UP || mode == M_DN) begin
                        state_d = S_RUN;
                        clr     = 1'b1;
                    end else if (mode == M_SWEEP && start) begin
                        state_d = S_SWEEP;
                        sel_d   = '0;
                        clr     = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (en) begin
                    // A load restarts the step interval and wins over a coincident tick.
                    if (load) begin
                        sel_d = load_val;
                        clr   = 1'b1;
                    end
                    if (mode == M_SWEEP || mode == M_HOLD) begin
                        state_d = S_IDLE;
                    end else if (!load && tick) begin
                        sel_d  = step_sel(sel_q, mode == M_DN);
                        wrap_d = (mode == M_DN) ? (sel_q == '0) : (sel_q == SEL_LAST);
                    end
                end
            end
            S_SWEEP: begin
                if (tick) begin
                    if (sel_q == SEL_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end
            end
            default: begin
                sel_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Status flags follow the next state so they line up with the registered sel.
        sel_valid_d = (state_d == S_RUN) || (state_d == S_SWEEP);
        busy_d      = (state_d == S_SWEEP);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            wrap_q      <= wrap_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign wrap      = wrap_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_scan_seq_3b.sv
// Scoreboard bench for scan_seq_3b (DIV=4): stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them and also watches the wrap/done exclusivity rules.
module tb_scan_seq_3b;

    localparam int DIV   = 4;
    localparam int SEL_W = 3;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             en       = 1'b0;
    logic [1:0]       mode     = 2'b11;
    logic             start    = 1'b0;
    logic             load     = 1'b0;
    logic [SEL_W-1:0] load_val = '0;
    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic             wrap;
    logic             busy;
    logic             done;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int               cyc;
        logic [SEL_W-1:0] sel;
        logic             vld;
        logic             wrap;
        logic             busy;
        logic             done;
        string            nm;
    } exp_t;

    exp_t exp_q[$];

    scan_seq_3b #(.DIV(DIV), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .start     (start),
        .load      (load),
        .load_val  (load_val),
        .sel       (sel),
        .sel_valid (sel_valid),
        .wrap      (wrap),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges seen; "period K" is the interval after edge K.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_span(input int c0, input int c1, input logic [SEL_W-1:0] s,
                               input logic v, input logic w, input logic b, input logic d,
                               input string nm);
        for (int c = c0; c <= c1; c++) begin
            exp_q.push_back('{c, s, v, w, b, d, nm});
        end
    endtask

    task automatic check_now(input string nm, input logic [SEL_W-1:0] s,
                             input logic v, input logic w, input logic b, input logic d);
        checks++;
        if ({sel, sel_valid, wrap, busy, done} !== {s, v, w, b, d}) begin
            errors++;
            $display("FAIL %s @t=%0t: got sel=%0d vld=%b wrap=%b busy=%b done=%b, expected sel=%0d vld=%b wrap=%b busy=%b done=%b",
                     nm, $time, sel, sel_valid, wrap, busy, done, s, v, w, b, d);
        end
    endtask

    // Monitor: compare every queued expectation in its period, plus per-cycle exclusivity rules.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d reached only at cycle %0d", e.nm, e.cyc, cyc);
            end else if ({sel, sel_valid, wrap, busy, done} !== {e.sel, e.vld, e.wrap, e.busy, e.done}) begin
                errors++;
                $display("FAIL %s @cyc %0d: got sel=%0d vld=%b wrap=%b busy=%b done=%b, expected sel=%0d vld=%b wrap=%b busy=%b done=%b",
                         e.nm, cyc, sel, sel_valid, wrap, busy, done, e.sel, e.vld, e.wrap, e.busy, e.done);
            end
        end
        if (!rst) begin
            checks++;
            if ((wrap && busy) || (done && (sel_valid || busy || wrap))) begin
                errors++;
                $display("FAIL exclusivity @cyc %0d: got wrap=%b busy=%b done=%b vld=%b, expected no wrap in sweep and done alone",
                         cyc, wrap, busy, done, sel_valid);
            end
        end
    end

    initial begin
        int c;

        // Reset held from time 0: outputs must be clear before any clock edge.
        #2;
        check_now("reset_no_clk", 0, 0, 0, 0, 0);
        step(2);
        check_now("reset_held", 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Continuous up: 4 periods per index, wrap exactly on the 7->0 update.
        c = cyc;
        en = 1'b1;
        mode = 2'b00;
        for (int k = 0; k < 8; k++) begin
            expect_span(c + 1 + 4*k, c + 4 + 4*k, 3'(k), 1, 0, 0, 0, "up_step");
        end
        expect_span(c + 33, c + 33, 0, 1, 1, 0, 0, "up_wrap");
        expect_span(c + 34, c + 34, 0, 1, 0, 0, 0, "up_after_wrap");
        step(34);
        mode = 2'b11;
        expect_span(c + 35, c + 35, 0, 0, 0, 0, 0, "up_to_idle");
        step(1);

        // Continuous down from a loaded 2: 2,1,0,7 with wrap only on 0->7.
        c = cyc;
        mode = 2'b01;
        load = 1'b1;
        load_val = 3'd2;
        expect_span(c + 1,  c + 4,  2, 1, 0, 0, 0, "dn_load2");
        expect_span(c + 5,  c + 8,  1, 1, 0, 0, 0, "dn_step1");
        expect_span(c + 9,  c + 12, 0, 1, 0, 0, 0, "dn_step0");
        expect_span(c + 13, c + 13, 7, 1, 1, 0, 0, "dn_wrap");
        expect_span(c + 14, c + 14, 7, 1, 0, 0, 0, "dn_after_wrap");
        step(1);
        load = 1'b0;
        step(13);
        mode = 2'b11;
        expect_span(c + 15, c + 15, 7, 0, 0, 0, 0, "dn_to_idle");
        step(1);

        // Load coincident with the 5->6 tick: sel=3, no step, no wrap, next step 4 later.
        c = cyc;
        mode = 2'b00;
        load = 1'b1;
        load_val = 3'd0;
        for (int k = 0; k < 6; k++) begin
            expect_span(c + 1 + 4*k, c + 4 + 4*k, 3'(k), 1, 0, 0, 0, "ld_run");
        end
        expect_span(c + 25, c + 28, 3, 1, 0, 0, 0, "ld_over_tick");
        expect_span(c + 29, c + 29, 4, 1, 0, 0, 0, "ld_next_step");
        step(1);
        load = 1'b0;
        step(23);
        load = 1'b1;
        load_val = 3'd3;
        step(1);
        load = 1'b0;
        step(4);
        mode = 2'b11;
        expect_span(c + 30, c + 30, 4, 0, 0, 0, 0, "ld_to_idle");
        step(1);

        // Sweep: start in period c, done in period c+33; mid-sweep start/load/mode ignored.
        c = cyc;
        mode = 2'b10;
        start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            expect_span(c + 1 + 4*k, c + 4 + 4*k, 3'(k), 1, 0, 1, 0, "sweep_idx");
        end
        expect_span(c + 33, c + 33, 7, 0, 0, 0, 1, "sweep_done");
        expect_span(c + 34, c + 35, 0, 0, 0, 0, 0, "sweep_idle");
        step(1);
        start = 1'b0;
        step(9);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        load = 1'b1;
        load_val = 3'd6;
        step(1);
        load = 1'b0;
        step(5);
        mode = 2'b00;
        step(1);
        mode = 2'b10;
        step(14);

        // Sweep paused by en=0 while at index 2, then reset asynchronously at index 4.
        c = cyc;
        start = 1'b1;
        expect_span(c + 1,  c + 4,  0, 1, 0, 1, 0, "pause_idx0");
        expect_span(c + 5,  c + 8,  1, 1, 0, 1, 0, "pause_idx1");
        expect_span(c + 9,  c + 18, 2, 1, 0, 1, 0, "pause_frozen_idx2");
        expect_span(c + 19, c + 22, 3, 1, 0, 1, 0, "pause_idx3");
        expect_span(c + 23, c + 23, 4, 1, 0, 1, 0, "pause_idx4");
        step(1);
        start = 1'b0;
        step(9);
        en = 1'b0;
        step(6);
        en = 1'b1;
        step(8);
        #2;
        check_now("pre_rst_sweep", 4, 1, 0, 1, 0);
        rst = 1'b1;
        #1;
        check_now("rst_mid_sweep", 0, 0, 0, 0, 0);
        step(1);
        rst = 1'b0;
        c = cyc;
        expect_span(c + 1, c + 20, 0, 0, 0, 0, 0, "post_rst_no_done");
        step(20);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            step(1);
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
        $fatal(1, "time limit");
    end

endmodule
